exec_trace_buffer: RTL and testbench
====================================

// Module: exec_trace_buffer
// PURPOSE
//  Consumer end of the datapath's observation interface (Instruction, NextPC, ALUResult).
//  Captures one 3-word trace entry per clock into a circular FIFO.
//  Streams the captured entries out as 32-bit words over a valid/ready port to a host or checker.
//  Sits beside the single-cycle datapath and lets retired-instruction traces be drained at the consumer's pace.
// PARAMETERS
//  DEPTH    16  trace entries stored; power of two, >=2
//  ADDR_W   4   log2(DEPTH)
// PORTS
//  clock        in   1         single clock, all state updates on rising edge
//  Reset        in   1         synchronous, active-high; clears all state
//  capture_en   in   1         1 = sample the datapath outputs on this edge
//  clear        in   1         synchronous flush of FIFO, overflow flag and drop counter
//  Instruction  in   32        datapath instruction word
//  NextPC       in   32        datapath next-PC value
//  ALUResult    in   32        datapath ALU result
//  out_data     out  32        current output word
//  out_valid    out  1         out_data holds a valid word
//  out_ready    in   1         consumer accepts out_data on this edge when out_valid=1
//  out_last     out  1         1 on the third (final) word of an entry
//  count        out  ADDR_W+1  entries stored, 0..DEPTH
//  full         out  1         count==DEPTH
//  overflow     out  1         sticky: at least one capture was dropped
//  drop_cnt     out  8         dropped captures, saturates at 255
// BEHAVIOUR
//  Reset (sync, priority over all): wr_ptr=rd_ptr=0, count=0, word index=W0, overflow=0, drop_cnt=0.
//   Outputs after the edge: out_valid=0, out_last=0, full=0.
//   An entry partially streamed at reset is discarded; the memory contents themselves are not cleared.
//  clear=1 (no Reset): same effect as Reset; second in priority; capture and pop in that cycle are ignored.
//  Capture:
//   capture_en=1 and full=0 (registered value, before the edge): write {Instruction,NextPC,ALUResult} at wr_ptr.
//   Then wr_ptr+1 mod DEPTH.
//   capture_en=1 and full=1: entry dropped, overflow<=1, drop_cnt<=min(drop_cnt+1,255).
//   A pop in the same cycle does NOT rescue a dropped capture (full is evaluated pre-edge).
//  Read FSM (word index): W0 -> W1 -> W2 -> W0, advancing only on out_valid & out_ready.
//   W0 outputs Instruction, W1 outputs NextPC, W2 outputs ALUResult; out_last=1 only in W2 with out_valid=1.
//   Handshake in W2 pops the entry: rd_ptr+1 mod DEPTH.
//  out_valid = (count!=0). out_data is a combinational mux of mem[rd_ptr] by word index.
//   It is stable while out_valid & !out_ready.
//  Latency: an entry captured at edge N drives out_valid=1 from edge N onward (i.e. in cycle N+1) if the FIFO was empty.
//  count: +1 on accepted capture, -1 on pop, unchanged when both occur in the same edge.
//  Simultaneous capture and pop at count==DEPTH-1 or 1: both take effect, count unchanged.
//  Pointer wrap: wr_ptr/rd_ptr wrap DEPTH-1 -> 0. The FIFO never overwrites unread entries.
//  overflow and drop_cnt clear only on Reset or clear.
// TESTING
//  1. Reset=1 one edge, then idle -> out_valid=0, count=0, full=0, overflow=0, drop_cnt=0.
//  2. Capture one entry (I=0x00500093, PC=0x4, ALU=0x5), out_ready=1
//     -> words 0x00500093, 0x4, 0x5 on 3 consecutive edges, out_last on the 3rd, count back to 0.
//  3. out_ready=0, capture 18 consecutive entries with DEPTH=16
//     -> full=1 after 16, overflow=1, drop_cnt=2; draining yields entries 1..16 in order.
//  4. FIFO full, capture_en=1 and W2 pop on the same edge
//     -> capture dropped (drop_cnt+1), count=15; next capture accepted, count=16.
//  5. Stall out_ready=0 in W1 for 5 cycles -> out_data holds NextPC, out_valid=1, no advance; resume gives the W2 word.
//  6. Reset asserted mid-entry (word index W1, count=3) -> next cycle count=0, out_valid=0.
//     A new capture streams from W0.

Source files
------------

// File: rtl/exec_trace_buffer.sv
// exec_trace_buffer
// Captures one {Instruction, NextPC, ALUResult} trace entry per clock into a
// circular FIFO and streams the stored entries out as three 32-bit words per
// entry over a valid/ready port. Captures that arrive while the FIFO is full
// are dropped and counted; the FIFO never overwrites unread entries.
module exec_trace_buffer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              Reset,
    input  logic              capture_en,
    input  logic              clear,
    input  logic [31:0]       Instruction,
    input  logic [31:0]       NextPC,
    input  logic [31:0]       ALUResult,
    output logic [31:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              overflow,
    output logic [7:0]        drop_cnt
);

    // Word index of the entry at the head of the FIFO
    typedef enum logic [1:0] {
        W0 = 2'd0,
        W1 = 2'd1,
        W2 = 2'd2
    } word_t;

    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W + 1)'(DEPTH);

    word_t             word_reg;
    word_t             word_next;
    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [ADDR_W:0]   count_reg;
    logic              overflow_reg;
    logic [7:0]        drop_cnt_reg;

    logic              flush;
    logic              handshake;
    logic              push;
    logic              pop;
    logic              drop;

    // Per-lane view of the incoming entry and of the head entry
    logic [31:0]       capt_word [3];
    logic [31:0]       head_word [3];

    assign capt_word[0] = Instruction;
    assign capt_word[1] = NextPC;
    assign capt_word[2] = ALUResult;

    // Reset and clear share one flush path; Reset simply wins if both are high,
    // which has the same effect.
    assign flush     = Reset | clear;
    assign full      = (count_reg == CNT_FULL);
    assign out_valid = (count_reg != '0);
    assign handshake = out_valid & out_ready;
    // full is the registered value, so a pop on the same edge cannot make
    // room for a capture.
    assign push      = capture_en & ~full;
    assign drop      = capture_en & full;
    assign pop       = handshake & (word_reg == W2);

    // One memory lane per word of the entry; asynchronous read at rd_ptr so
    // the head word is visible in the same cycle count becomes non-zero.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_lane
            logic [31:0] mem [DEPTH];

            // Write the lane when a capture is accepted (contents survive flush)
            always_ff @(posedge clock) begin
                if (!flush && push) begin
                    mem[wr_ptr_reg] <= capt_word[gi];
                end
            end

            assign head_word[gi] = mem[rd_ptr_reg];
        end
    endgenerate

    // Next word index: advance W0 -> W1 -> W2 -> W0 on each accepted word
    always_comb begin
        word_next = word_reg;
        if (handshake) begin
            unique case (word_reg)
                W0:      word_next = W1;
                W1:      word_next = W2;
                W2:      word_next = W0;
                default: word_next = W0;
            endcase
        end
    end

    // Output word mux and end-of-entry marker
    always_comb begin
        out_data = head_word[0];
        out_last = 1'b0;
        unique case (word_reg)
            W0:      out_data = head_word[0];
            W1:      out_data = head_word[1];
            W2: begin
                out_data = head_word[2];
                out_last = out_valid;
            end
            default: out_data = head_word[0];
        endcase
    end

    // Word index state register
    always_ff @(posedge clock) begin
        if (flush) begin
            word_reg <= W0;
        end else begin
            word_reg <= word_next;
        end
    end

    // Pointers, occupancy and drop bookkeeping
    always_ff @(posedge clock) begin
        if (flush) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            drop_cnt_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_reg <= count_reg + (ADDR_W + 1)'(1);
                2'b01:   count_reg <= count_reg - (ADDR_W + 1)'(1);
                default: count_reg <= count_reg;
            endcase
            if (drop) begin
                overflow_reg <= 1'b1;
                if (drop_cnt_reg != 8'hFF) begin
                    drop_cnt_reg <= drop_cnt_reg + 8'd1;
                end
            end
        end
    end

    assign count    = count_reg;
    assign overflow = overflow_reg;
    assign drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_exec_trace_buffer.sv
// Testbench for exec_trace_buffer: directed scenarios followed by random
// traffic, all checked each cycle against a queue-based reference model.
module tb_exec_trace_buffer;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clock;
    logic              Reset;
    logic              capture_en;
    logic              clear;
    logic [31:0]       Instruction;
    logic [31:0]       NextPC;
    logic [31:0]       ALUResult;
    logic [31:0]       out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              overflow;
    logic [7:0]        drop_cnt;

    exec_trace_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clock      (clock),
        .Reset      (Reset),
        .capture_en (capture_en),
        .clear      (clear),
        .Instruction(Instruction),
        .NextPC     (NextPC),
        .ALUResult  (ALUResult),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .count      (count),
        .full       (full),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: queue of whole entries plus a word position
    logic [2:0][31:0] q [$];
    int               m_widx;
    bit               m_ovf;
    int               m_drops;
    bit               m_known;

    int n_cmp;
    int n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output with the model's pre-edge view
    task automatic check_model();
        bit v;
        v = (q.size() != 0);
        chk("out_valid", 32'(out_valid), 32'(v));
        chk("count", 32'(count), q.size());
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("drop_cnt", 32'(drop_cnt), m_drops);
        chk("out_last", 32'(out_last), 32'(v && m_widx == 2));
        if (v) begin
            chk("out_data", out_data, q[0][m_widx]);
        end
    endtask

    // Apply one rising edge to the model using the inputs currently driven
    task automatic model_edge();
        bit was_full;
        bit hs;
        logic [2:0][31:0] e;
        if (Reset || clear) begin
            q.delete();
            m_widx  = 0;
            m_ovf   = 1'b0;
            m_drops = 0;
            m_known = 1'b1;
        end else begin
            was_full = (q.size() == DEPTH);
            hs = (q.size() != 0) && out_ready;
            if (hs) begin
                if (m_widx == 2) begin
                    e = q.pop_front();
                    $display("pop   I=%h PC=%h ALU=%h", e[0], e[1], e[2]);
                end
                m_widx = (m_widx + 1) % 3;
            end
            if (capture_en) begin
                if (was_full) begin
                    m_ovf = 1'b1;
                    if (m_drops < 255) m_drops++;
                end else begin
                    e[0] = Instruction;
                    e[1] = NextPC;
                    e[2] = ALUResult;
                    q.push_back(e);
                end
            end
        end
    endtask

    task automatic tick();
        if (m_known) check_model();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic set_entry(input logic [31:0] i, input logic [31:0] pc, input logic [31:0] alu);
        Instruction = i;
        NextPC      = pc;
        ALUResult   = alu;
    endtask

    initial begin
        int drops_before;
        n_cmp = 0;
        n_err = 0;
        m_known = 1'b0;
        m_widx = 0;
        m_ovf = 1'b0;
        m_drops = 0;
        Reset = 1'b1;
        clear = 1'b0;
        capture_en = 1'b0;
        out_ready = 1'b0;
        set_entry(32'h0, 32'h0, 32'h0);
        #2;

        // 1. Reset, then idle
        tick();
        Reset = 1'b0;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        tick();

        // 2. Single entry streamed with out_ready held high
        capture_en = 1'b1;
        out_ready = 1'b1;
        set_entry(32'h00500093, 32'h4, 32'h5);
        tick();
        capture_en = 1'b0;
        chk("t2_w0", out_data, 32'h00500093);
        tick();
        chk("t2_w1", out_data, 32'h4);
        tick();
        chk("t2_w2", out_data, 32'h5);
        chk("t2_last", 32'(out_last), 32'd1);
        tick();
        chk("t2_count", 32'(count), 32'd0);

        // 3. Overfill with 18 captures, then drain
        out_ready = 1'b0;
        capture_en = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            set_entry(32'h1000 + k, 32'h4 * k, 32'hA000 + k);
            tick();
        end
        capture_en = 1'b0;
        chk("t3_full", 32'(full), 32'd1);
        chk("t3_ovf", 32'(overflow), 32'd1);
        chk("t3_drop", 32'(drop_cnt), 32'd2);
        chk("t3_first", out_data, 32'h1001);
        out_ready = 1'b1;
        for (int k = 0; k < 3 * DEPTH; k++) tick();
        chk("t3_empty", 32'(count), 32'd0);

        // 4. Full FIFO, capture coincides with a W2 pop: capture still dropped
        out_ready = 1'b0;
        capture_en = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            set_entry(32'h2000 + k, 32'h100 + k, 32'h300 + k);
            tick();
        end
        capture_en = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        drops_before = m_drops;
        capture_en = 1'b1;
        set_entry(32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003);
        tick();
        chk("t4_count15", 32'(count), 32'd15);
        chk("t4_drop", 32'(drop_cnt), 32'(drops_before + 1));
        out_ready = 1'b0;
        set_entry(32'hBEEF0001, 32'hBEEF0002, 32'hBEEF0003);
        tick();
        capture_en = 1'b0;
        chk("t4_count16", 32'(count), 32'd16);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_ovf", 32'(overflow), 32'd0);
        chk("clr_drop", 32'(drop_cnt), 32'd0);

        // 5. Stall in W1 for five cycles
        capture_en = 1'b1;
        set_entry(32'h11111111, 32'h22222222, 32'h33333333);
        tick();
        capture_en = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("t5_hold", out_data, 32'h22222222);
            chk("t5_valid", 32'(out_valid), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("t5_w2", out_data, 32'h33333333);
        tick();

        // 6. Reset in the middle of an entry
        out_ready = 1'b0;
        capture_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_entry(32'h3000 + k, 32'h3100 + k, 32'h3200 + k);
            tick();
        end
        capture_en = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t6_count3", 32'(count), 32'd3);
        chk("t6_w1", out_data, 32'h3100);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("t6_count0", 32'(count), 32'd0);
        chk("t6_valid0", 32'(out_valid), 32'd0);
        capture_en = 1'b1;
        set_entry(32'h44440000, 32'h44440004, 32'h44440008);
        tick();
        capture_en = 1'b0;
        chk("t6_w0", out_data, 32'h44440000);

        // Random traffic in phases of varying consumer speed
        for (int ph = 0; ph < 6; ph++) begin
            int rdy_pct;
            rdy_pct = (ph % 3 == 0) ? 15 : ((ph % 3 == 1) ? 50 : 90);
            for (int k = 0; k < 300; k++) begin
                capture_en = ($urandom_range(99) < 60);
                out_ready  = ($urandom_range(99) < rdy_pct);
                clear      = ($urandom_range(199) == 0);
                Reset      = ($urandom_range(399) == 0);
                set_entry($urandom, $urandom, $urandom);
                tick();
            end
        end
        Reset = 1'b0;
        clear = 1'b0;
        capture_en = 1'b0;
        out_ready = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
